stacked_regfile_instance: RTL and testbench
===========================================

Name: stacked_regfile_instance

Overview:
- One register bank (frame) of the stacked register file: NUM_REGS registers of WIDTH bits each.
- Each clock edge does one of three things, chosen by a 2-bit command:
  - push: load the whole bank from the push-side data.
  - pop: load the whole bank from the pop-side data.
  - none: keep the current contents.
- Instances are chained by the stacked-regfile top level. Push data comes from the frame above and pop data from the frame below, so that banks shift on interrupt entry/exit.

Parameters:
- NUM_REGS, 32, number of registers in the bank.
- WIDTH, 32, bits per register.
- DEPTH_MAX, 15, saturation value of the optional depth counter (used only when REGFILE_DEPTH_EN is defined).

Ports:
- i_clk  input  1  system clock, rising-edge active.
- i_reset  input  1  reset, asynchronous, active-high; clears the bank.
- i_command  input  2  command, type Command from package veryl_stacked_regfile_RegFilePkg: Command_none=2'd0, Command_push=2'd1, Command_pop=2'd2; 2'd3 reserved.
- i_push_data  input  WIDTH x [NUM_REGS] (unpacked array)  values loaded on push.
- i_pop_data  input  WIDTH x [NUM_REGS] (unpacked array)  values loaded on pop.
- o_data  output  WIDTH x [NUM_REGS] (unpacked array)  current register contents, driven directly from flops.
- o_depth  output  $clog2(DEPTH_MAX+1)  push/pop depth; present only with REGFILE_DEPTH_EN.

Behaviour:
- Storage is one flop array r[NUM_REGS][WIDTH]; o_data[k] = r[k] combinationally, with no output logic.
- Reset:
  - While i_reset=1, all r[k]=0 immediately, without waiting for a clock edge, and every clock edge is ignored.
  - Deassertion is asynchronous; the first rising edge with i_reset=0 executes i_command normally.
- Rising edge of i_clk with i_reset=0:
  - Command_push: r[k] <= i_push_data[k] for all k in the same edge. One-cycle latency; visible on o_data right after the edge.
  - Command_pop: r[k] <= i_pop_data[k] for all k.
  - Command_none: r unchanged; i_push_data and i_pop_data are ignored.
  - Reserved 2'd3: treated as Command_none.
- Register 0 is an ordinary register, not hardwired to zero; zero-register semantics belong to the enclosing core.
- No handshake and no busy state; a new command is accepted every cycle. Back-to-back push/pop is legal, and each edge takes the data present at that edge.
- Reset mid-sequence discards all contents. After reset release with Command_none, the bank stays all-zero.
- Data inputs are sampled only at the edge; changes between edges have no effect on o_data.
- Width rule: data is copied bit-exact, with no arithmetic, extension or truncation.

Optional Feature:
- Macro: REGFILE_DEPTH_EN.
- Defined:
  - Adds port o_depth and a depth counter, reset to 0 asynchronously.
  - push increments the counter, saturating at DEPTH_MAX.
  - pop decrements the counter, saturating at 0.
  - none and the reserved command hold the counter.
  - Saturation never blocks the data load.
- Not defined: no o_depth port, no counter logic; data behaviour is identical in both builds.

Test Plan:
- Reset: i_reset=1, command push, push_data[0]=1, [1]=2, one clock -> o_data[0]=0, o_data[1]=0.
- Push: release reset, Command_push, push_data[0]=1, [1]=2, one clock -> o_data[0]=1, o_data[1]=2; other registers equal their push_data.
- Pop: Command_pop, pop_data[0]=3, [1]=4, one clock -> o_data[0]=3, o_data[1]=4.
- Hold: Command_none, push_data {42,43}, pop_data {44,45}, one clock -> o_data stays {3,4}. Repeat with command 2'd3 -> still {3,4}.
- Async re-reset: assert i_reset between edges -> o_data all zero before the next edge. Release reset, Command_none, one clock -> o_data[0]=0, o_data[1]=0.
- With REGFILE_DEPTH_EN:
  - 16 pushes with DEPTH_MAX=15 -> o_depth=15.
  - 17 pops -> o_depth=0.
  - o_data tracks every load throughout.

Source files
------------

// File: rtl/stacked_regfile_instance.sv
`default_nettype none
// ============================================================================
// Module   : stacked_regfile_instance
// Brief    : One frame of the stacked register file. The whole bank loads from
//            the frame above on push or from the frame below on pop.
//            Optional depth counter enabled by macro REGFILE_DEPTH_EN.
// Revision : 1.0 - initial release
// ============================================================================

package veryl_stacked_regfile_RegFilePkg;
    typedef enum logic [1:0] {
        Command_none = 2'd0,
        Command_push = 2'd1,
        Command_pop  = 2'd2
    } Command;
endpackage

module stacked_regfile_instance #(
    parameter int NUM_REGS  = 32,
    parameter int WIDTH     = 32,
    parameter int DEPTH_MAX = 15
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  veryl_stacked_regfile_RegFilePkg::Command i_command,
    input  logic [WIDTH-1:0]                    i_push_data [NUM_REGS],
    input  logic [WIDTH-1:0]                    i_pop_data  [NUM_REGS],
    output logic [WIDTH-1:0]                    o_data      [NUM_REGS]
`ifdef REGFILE_DEPTH_EN
    ,
    output logic [$clog2(DEPTH_MAX+1)-1:0]      o_depth
`endif
);

    import veryl_stacked_regfile_RegFilePkg::*;

    localparam int C_DEPTH_W = $clog2(DEPTH_MAX + 1);

    // Reject configurations that cannot form a meaningful bank or counter.
    if (NUM_REGS < 1 || WIDTH < 1 || DEPTH_MAX < 1 || C_DEPTH_W < 1) begin : g_param_check
        $error("stacked_regfile_instance: NUM_REGS, WIDTH and DEPTH_MAX must be >= 1");
    end

    logic [WIDTH-1:0] r_bank_q [NUM_REGS];
    logic [WIDTH-1:0] w_bank_d [NUM_REGS];

    // Reserved encoding 2'd3 falls into the default arm and holds the bank.
    always_comb begin
        w_bank_d = r_bank_q;
        case (i_command)
            Command_push: w_bank_d = i_push_data;
            Command_pop:  w_bank_d = i_pop_data;
            default:      w_bank_d = r_bank_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_bank_q[k] <= '0;
            end
        end else begin
            r_bank_q <= w_bank_d;
        end
    end

    assign o_data = r_bank_q;

`ifdef REGFILE_DEPTH_EN
    localparam logic [C_DEPTH_W-1:0] C_DEPTH_MAX = C_DEPTH_W'(DEPTH_MAX);

    logic [C_DEPTH_W-1:0] r_depth_q;
    logic [C_DEPTH_W-1:0] w_depth_d;

    // Saturation only freezes the counter; the data load above is unaffected.
    always_comb begin
        w_depth_d = r_depth_q;
        case (i_command)
            Command_push: begin
                if (r_depth_q != C_DEPTH_MAX) begin
                    w_depth_d = r_depth_q + C_DEPTH_W'(1);
                end
            end
            Command_pop: begin
                if (r_depth_q != '0) begin
                    w_depth_d = r_depth_q - C_DEPTH_W'(1);
                end
            end
            default: w_depth_d = r_depth_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_depth_q <= '0;
        end else begin
            r_depth_q <= w_depth_d;
        end
    end

    assign o_depth = r_depth_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stacked_regfile_instance.sv
`default_nettype none
// ============================================================================
// Module   : tb_stacked_regfile_instance
// Brief    : Directed self-checking bench for stacked_regfile_instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stacked_regfile_instance;

    import veryl_stacked_regfile_RegFilePkg::*;

    localparam int C_NUM_REGS  = 32;
    localparam int C_WIDTH     = 32;
    localparam int C_DEPTH_MAX = 15;

    logic                 clk = 1'b0;
    logic                 rst;
    Command               cmd;
    logic [C_WIDTH-1:0]   push_data [C_NUM_REGS];
    logic [C_WIDTH-1:0]   pop_data  [C_NUM_REGS];
    logic [C_WIDTH-1:0]   data      [C_NUM_REGS];
`ifdef REGFILE_DEPTH_EN
    logic [$clog2(C_DEPTH_MAX+1)-1:0] depth;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    stacked_regfile_instance #(
        .NUM_REGS  (C_NUM_REGS),
        .WIDTH     (C_WIDTH),
        .DEPTH_MAX (C_DEPTH_MAX)
    ) u_dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_command   (cmd),
        .i_push_data (push_data),
        .i_pop_data  (pop_data),
        .o_data      (data)
`ifdef REGFILE_DEPTH_EN
        ,
        .o_depth     (depth)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset holds the bank at zero even with a push pending.
        rst = 1'b1;
        cmd = Command_push;
        for (int k = 0; k < C_NUM_REGS; k++) begin
            push_data[k] = 32'(k + 1);
            pop_data[k]  = 32'h0;
        end
        #2;
        tick();
        check_eq("reset_r0", data[0], 32'd0);
        check_eq("reset_r1", data[1], 32'd0);
`ifdef REGFILE_DEPTH_EN
        check_eq("reset_depth", 32'(depth), 32'd0);
`endif

        rst = 1'b0;
        cmd = Command_push;
        tick();
        check_eq("push_r0", data[0], 32'd1);
        check_eq("push_r1", data[1], 32'd2);
        for (int k = 2; k < C_NUM_REGS; k++) check_eq("push_rk", data[k], 32'(k + 1));

        for (int k = 0; k < C_NUM_REGS; k++) pop_data[k] = 32'(k + 3);
        cmd = Command_pop;
        tick();
        check_eq("pop_r0", data[0], 32'd3);
        check_eq("pop_r1", data[1], 32'd4);
        check_eq("pop_r31", data[31], 32'd34);

        // Hold: both data inputs change but must be ignored.
        for (int k = 0; k < C_NUM_REGS; k++) begin
            push_data[k] = 32'(42 + 2 * k);
            pop_data[k]  = 32'(44 + 2 * k);
        end
        push_data[1] = 32'd43;
        pop_data[1]  = 32'd45;
        cmd = Command_none;
        tick();
        check_eq("hold_r0", data[0], 32'd3);
        check_eq("hold_r1", data[1], 32'd4);
        check_eq("hold_r20", data[20], 32'd23);
        cmd = Command'(2'd3);
        tick();
        check_eq("rsvd_r0", data[0], 32'd3);
        check_eq("rsvd_r1", data[1], 32'd4);
        check_eq("rsvd_r9", data[9], 32'd12);

        // Push operands arrive mid-cycle; nothing changes until the edge.
        cmd = Command_push;
        for (int k = 0; k < C_NUM_REGS; k++) push_data[k] = 32'hDEAD_0000 | 32'(k);
        push_data[0] = 32'hFFFF_FFFF;
        push_data[1] = 32'h8000_0001;
        #2;
        check_eq("between_edges_r0", data[0], 32'd3);
        tick();
        check_eq("wide_r0", data[0], 32'hFFFF_FFFF);
        check_eq("wide_r1", data[1], 32'h8000_0001);
        check_eq("wide_r17", data[17], 32'hDEAD_0011);

        // Back-to-back pop after push.
        for (int k = 0; k < C_NUM_REGS; k++) pop_data[k] = 32'hA5A5_5A5A ^ 32'(k);
        cmd = Command_pop;
        tick();
        check_eq("b2b_pop_r0", data[0], 32'hA5A5_5A5A);
        check_eq("b2b_pop_r5", data[5], 32'hA5A5_5A5F);
        cmd = Command_push;
        tick();
        check_eq("b2b_push_r2", data[2], 32'hDEAD_0002);

        // Asynchronous reset between edges.
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_r0", data[0], 32'd0);
        check_eq("async_rst_r2", data[2], 32'd0);
        tick();
        check_eq("rst_edge_ignored_r2", data[2], 32'd0);
        rst = 1'b0;
        cmd = Command_none;
        tick();
        check_eq("post_rst_none_r0", data[0], 32'd0);
        check_eq("post_rst_none_r1", data[1], 32'd0);
        check_eq("post_rst_none_r31", data[31], 32'd0);

`ifdef REGFILE_DEPTH_EN
        check_eq("depth_after_rst", 32'(depth), 32'd0);
        cmd = Command_push;
        for (int i = 0; i < 16; i++) begin
            push_data[0] = 32'(100 + i);
            tick();
            check_eq("depth_push", 32'(depth), (i + 1 > C_DEPTH_MAX) ? 32'(C_DEPTH_MAX) : 32'(i + 1));
            check_eq("depth_push_data", data[0], 32'(100 + i));
        end
        check_eq("depth_sat_hi", 32'(depth), 32'd15);
        cmd = Command_pop;
        for (int i = 0; i < 17; i++) begin
            pop_data[0] = 32'(200 + i);
            tick();
            check_eq("depth_pop", 32'(depth), (i + 1 >= 15) ? 32'd0 : 32'(14 - i));
            check_eq("depth_pop_data", data[0], 32'(200 + i));
        end
        check_eq("depth_sat_lo", 32'(depth), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
